reservation_station: RTL and testbench

Reservation station between the rename stage (map table) and the functional unit. It accepts one renamed instruction per cycle: operation, destination ROB tag, and two source operands, each tagged with a map-table data status. Waiting operands snoop the CDB for their ROB tag. The station issues the oldest instruction whose operands are both available.

---
 rtl/reservation_station.sv | 198 +++++++++++++++++++
 tb/tb_reservation_station.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Age-ordered reservation station: holds renamed instructions, snoops the CDB, issues the oldest ready one.
// Define RS_CDB_BYPASS_EN to let a CDB broadcast make an entry issuable in the same cycle.
module reservation_station #(
   parameter int RS_DEPTH = 4,
   parameter int TAG_W    = 3,
   parameter int XLEN     = 32,
   parameter int OP_W     = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      disp_valid,
   output logic                      disp_ready,
   input  logic [OP_W-1:0]           disp_op,
   input  logic [TAG_W-1:0]          disp_dest_tag,
   input  logic [1:0]                disp_src1_stat,
   input  logic [1:0]                disp_src2_stat,
   input  logic [TAG_W-1:0]          disp_src1_tag,
   input  logic [TAG_W-1:0]          disp_src2_tag,
   input  logic [XLEN-1:0]           disp_src1_val,
   input  logic [XLEN-1:0]           disp_src2_val,
   input  logic                      cdb_valid,
   input  logic [TAG_W-1:0]          cdb_tag,
   input  logic [XLEN-1:0]           cdb_val,
   input  logic                      flush,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [OP_W-1:0]           issue_op,
   output logic [TAG_W-1:0]          issue_dest_tag,
   output logic [XLEN-1:0]           issue_src1,
   output logic [XLEN-1:0]           issue_src2,
   output logic [$clog2(RS_DEPTH):0] occupancy
);
   localparam int OCC_W = $clog2(RS_DEPTH) + 1;
   localparam logic [TAG_W-1:0] NO_TAG = '1;
   localparam logic [1:0] STAT_WAIT = 2'b10;

   logic [RS_DEPTH-1:0] valid_q, valid_d;
   logic [RS_DEPTH-1:0] s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
   logic [OP_W-1:0]     op_q [RS_DEPTH];
   logic [OP_W-1:0]     op_d [RS_DEPTH];
   logic [TAG_W-1:0]    dest_q [RS_DEPTH];
   logic [TAG_W-1:0]    dest_d [RS_DEPTH];
   logic [TAG_W-1:0]    s1_tag_q [RS_DEPTH];
   logic [TAG_W-1:0]    s1_tag_d [RS_DEPTH];
   logic [TAG_W-1:0]    s2_tag_q [RS_DEPTH];
   logic [TAG_W-1:0]    s2_tag_d [RS_DEPTH];
   logic [XLEN-1:0]     s1_val_q [RS_DEPTH];
   logic [XLEN-1:0]     s1_val_d [RS_DEPTH];
   logic [XLEN-1:0]     s2_val_q [RS_DEPTH];
   logic [XLEN-1:0]     s2_val_d [RS_DEPTH];
   // older_q[j][i] set means entry j was allocated before entry i
   logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
   logic [RS_DEPTH-1:0] older_d [RS_DEPTH];

   logic                cdb_live;
   logic [RS_DEPTH-1:0] hit1, hit2, src1_ok, src2_ok, eligible, pick;
   logic [RS_DEPTH-1:0] free_vec, alloc_oh;
   logic                disp_fire, issue_fire;
   logic                new_s1_rdy, new_s2_rdy;
   logic [XLEN-1:0]     new_s1_val, new_s2_val;

   assign cdb_live = cdb_valid && (cdb_tag != NO_TAG);

   generate
      for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_sel
         logic [RS_DEPTH-1:0] older_than_me;
         for (genvar gj = 0; gj < RS_DEPTH; gj++) begin : g_col
            assign older_than_me[gj] = older_q[gj][gi];
         end
         assign hit1[gi] = cdb_live && !s1_rdy_q[gi] && (s1_tag_q[gi] == cdb_tag);
         assign hit2[gi] = cdb_live && !s2_rdy_q[gi] && (s2_tag_q[gi] == cdb_tag);
         assign pick[gi] = eligible[gi] && !(|(eligible & older_than_me));
      end
   endgenerate

`ifdef RS_CDB_BYPASS_EN
   assign src1_ok = s1_rdy_q | hit1;
   assign src2_ok = s2_rdy_q | hit2;
`else
   assign src1_ok = s1_rdy_q;
   assign src2_ok = s2_rdy_q;
`endif

   assign eligible    = valid_q & src1_ok & src2_ok;
   assign issue_valid = |pick;
   assign disp_ready  = ~&valid_q;
   assign free_vec    = ~valid_q;
   assign alloc_oh    = free_vec & (~free_vec + RS_DEPTH'(1));
   assign disp_fire   = disp_valid && disp_ready && !flush;
   assign issue_fire  = issue_valid && issue_ready && !flush;

   // A waiting operand can be satisfied by the broadcast seen in its own dispatch cycle
   assign new_s1_rdy = (disp_src1_stat != STAT_WAIT) || (cdb_live && (disp_src1_tag == cdb_tag));
   assign new_s2_rdy = (disp_src2_stat != STAT_WAIT) || (cdb_live && (disp_src2_tag == cdb_tag));
   assign new_s1_val = (disp_src1_stat == STAT_WAIT) ? cdb_val : disp_src1_val;
   assign new_s2_val = (disp_src2_stat == STAT_WAIT) ? cdb_val : disp_src2_val;

   always_comb begin
      valid_d  = valid_q;
      s1_rdy_d = s1_rdy_q;
      s2_rdy_d = s2_rdy_q;
      for (int i = 0; i < RS_DEPTH; i++) begin
         op_d[i]     = op_q[i];
         dest_d[i]   = dest_q[i];
         s1_tag_d[i] = s1_tag_q[i];
         s2_tag_d[i] = s2_tag_q[i];
         s1_val_d[i] = s1_val_q[i];
         s2_val_d[i] = s2_val_q[i];
         older_d[i]  = older_q[i];
         if (valid_q[i] && hit1[i]) begin
            s1_rdy_d[i] = 1'b1;
            s1_val_d[i] = cdb_val;
         end
         if (valid_q[i] && hit2[i]) begin
            s2_rdy_d[i] = 1'b1;
            s2_val_d[i] = cdb_val;
         end
         if (issue_fire && pick[i]) begin
            valid_d[i] = 1'b0;
         end
         if (disp_fire && alloc_oh[i]) begin
            valid_d[i]  = 1'b1;
            op_d[i]     = disp_op;
            dest_d[i]   = disp_dest_tag;
            s1_rdy_d[i] = new_s1_rdy;
            s2_rdy_d[i] = new_s2_rdy;
            s1_tag_d[i] = disp_src1_tag;
            s2_tag_d[i] = disp_src2_tag;
            s1_val_d[i] = new_s1_val;
            s2_val_d[i] = new_s2_val;
            older_d[i]  = '0;
         end
      end
      // The new entry is younger than everything currently resident
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (disp_fire && alloc_oh[i]) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
               older_d[j][i] = valid_q[j];
            end
         end
      end
      if (flush) begin
         valid_d = '0;
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(valid_q[i]);
      end
   end

   always_comb begin
      issue_op       = '0;
      issue_dest_tag = '0;
      issue_src1     = '0;
      issue_src2     = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (pick[i]) begin
            issue_op       = issue_op | op_q[i];
            issue_dest_tag = issue_dest_tag | dest_q[i];
`ifdef RS_CDB_BYPASS_EN
            issue_src1     = issue_src1 | (s1_rdy_q[i] ? s1_val_q[i] : cdb_val);
            issue_src2     = issue_src2 | (s2_rdy_q[i] ? s2_val_q[i] : cdb_val);
`else
            issue_src1     = issue_src1 | s1_val_q[i];
            issue_src2     = issue_src2 | s2_val_q[i];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= '0;
         s1_rdy_q <= '0;
         s2_rdy_q <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            older_q[i] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         s1_rdy_q <= s1_rdy_d;
         s2_rdy_q <= s2_rdy_d;
         older_q  <= older_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q     <= op_d;
      dest_q   <= dest_d;
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
   end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed vector table, hand sequences, and a
// randomized run checked against an age-ordered queue model of the station.
module tb_reservation_station;
   localparam int DEPTH = 4;
   localparam logic [2:0] NO_TAG = 3'b111;
`ifdef RS_CDB_BYPASS_EN
   localparam int B = 1;
`else
   localparam int B = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_valid, disp_ready;
   logic [5:0]  disp_op;
   logic [2:0]  disp_dest_tag;
   logic [1:0]  disp_src1_stat, disp_src2_stat;
   logic [2:0]  disp_src1_tag, disp_src2_tag;
   logic [31:0] disp_src1_val, disp_src2_val;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        flush;
   logic        issue_valid, issue_ready;
   logic [5:0]  issue_op;
   logic [2:0]  issue_dest_tag;
   logic [31:0] issue_src1, issue_src2;
   logic [2:0]  occupancy;

   always #5 clk = ~clk;

   reservation_station #(.RS_DEPTH(DEPTH), .TAG_W(3), .XLEN(32), .OP_W(6)) dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_dest_tag(disp_dest_tag),
      .disp_src1_stat(disp_src1_stat), .disp_src2_stat(disp_src2_stat),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_dest_tag(issue_dest_tag), .issue_src1(issue_src1), .issue_src2(issue_src2),
      .occupancy(occupancy)
   );

   typedef struct {
      logic dv; logic [5:0] op; logic [2:0] dt;
      logic [1:0] st1; logic [2:0] tg1; logic [31:0] v1;
      logic [1:0] st2; logic [2:0] tg2; logic [31:0] v2;
      logic cv; logic [2:0] ct; logic [31:0] cval; logic fl; logic ir;
      logic iv; logic [5:0] iop; logic [2:0] idt; logic [31:0] is1; logic [31:0] is2;
      logic [2:0] occ; logic dr;
   } vec_t;

   typedef struct {
      logic [5:0] op; logic [2:0] dt;
      bit r1; logic [2:0] t1; logic [31:0] v1;
      bit r2; logic [2:0] t2; logic [31:0] v2;
   } ment_t;

   vec_t  tbl[$];
   ment_t mq[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int unsigned dv, op, dt, st1, tg1, v1, st2, tg2, v2,
                               input int unsigned cv, ct, cval, fl, ir);
      vec_t v;
      v.dv = 1'(dv);  v.op = 6'(op);   v.dt = 3'(dt);
      v.st1 = 2'(st1); v.tg1 = 3'(tg1); v.v1 = v1;
      v.st2 = 2'(st2); v.tg2 = 3'(tg2); v.v2 = v2;
      v.cv = 1'(cv);  v.ct = 3'(ct);   v.cval = cval; v.fl = 1'(fl); v.ir = 1'(ir);
      v.iv = 1'b0; v.iop = '0; v.idt = '0; v.is1 = '0; v.is2 = '0; v.occ = '0; v.dr = 1'b1;
      return v;
   endfunction

   task automatic add(input int unsigned dv, op, dt, st1, tg1, v1, st2, tg2, v2,
                      input int unsigned cv, ct, cval, fl, ir,
                      input int unsigned iv, iop, idt, is1, is2, occ, dr);
      vec_t v;
      v = mk(dv, op, dt, st1, tg1, v1, st2, tg2, v2, cv, ct, cval, fl, ir);
      v.iv = 1'(iv); v.iop = 6'(iop); v.idt = 3'(idt); v.is1 = is1; v.is2 = is2;
      v.occ = 3'(occ); v.dr = 1'(dr);
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      disp_valid = v.dv; disp_op = v.op; disp_dest_tag = v.dt;
      disp_src1_stat = v.st1; disp_src1_tag = v.tg1; disp_src1_val = v.v1;
      disp_src2_stat = v.st2; disp_src2_tag = v.tg2; disp_src2_val = v.v2;
      cdb_valid = v.cv; cdb_tag = v.ct; cdb_val = v.cval; flush = v.fl; issue_ready = v.ir;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] rand_stat();
      case ($urandom_range(0, 3))
         0:       return 2'b00;
         1:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   initial begin : main
      vec_t  v;
      ment_t ne;
      int    pick;
      int    n_before;
      bit    hit_ok;
      logic [31:0] e_s1, e_s2;

      //   dv op dt st1 tg1 v1     st2 tg2 v2     cv ct cval   fl ir | iv iop idt is1 is2 occ dr
      add(1, 1, 2, 0, 0, 5,     0, 0, 7,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  1, 1, 2, 5, 7, 1, 1);
      add(1, 2, 5, 2, 3, 0,     0, 0, 'h11,  0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 3, 'hAA,  0, 1,
          B, B ? 2 : 0, B ? 5 : 0, B ? 'hAA : 0, B ? 'h11 : 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,
          1 - B, B ? 0 : 2, B ? 0 : 5, B ? 0 : 'hAA, B ? 0 : 'h11, 1 - B, 1);
      add(1, 3, 6, 2, 1, 0,     0, 0, 'h22,  0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0, 1);
      add(1, 4, 7, 0, 0, 'h33,  0, 0, 'h44,  0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  1, 4, 7, 'h33, 'h44, 2, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 1, 'h55,  0, 1,
          B, B ? 3 : 0, B ? 6 : 0, B ? 'h55 : 0, B ? 'h22 : 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,
          1 - B, B ? 0 : 3, B ? 0 : 6, B ? 0 : 'h55, B ? 0 : 'h22, 1 - B, 1);
      add(1, 5, 1, 0, 0, 1,     0, 0, 2,     0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0, 1);
      add(1, 6, 3, 0, 0, 3,     0, 0, 4,     0, 0, 0,     0, 0,  1, 5, 1, 1, 2, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  1, 5, 1, 1, 2, 2, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  1, 6, 3, 3, 4, 1, 1);
      add(1, 7, 0, 2, 4, 0,     0, 0, 8,     1, 4, 9,     0, 1,  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  1, 7, 0, 9, 8, 1, 1);
      add(1, 8, 1, 2, 7, 0,     0, 0, 1,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 7, 'h77,  0, 1,  0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1, 1,  0, 0, 0, 0, 0, 1, 1);
      add(1, 9, 2, 2, 2, 0,     2, 2, 0,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 2, 'h66,  0, 1,
          B, B ? 9 : 0, B ? 2 : 0, B ? 'h66 : 0, B ? 'h66 : 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,
          1 - B, B ? 0 : 9, B ? 0 : 2, B ? 0 : 'h66, B ? 0 : 'h66, 1 - B, 1);
      add(0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0, 0, 1);

      reset = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         @(negedge clk);
         $display("vec %0d: issue_valid=%0b dest=%0d src1=0x%0h occ=%0d disp_ready=%0b",
                  i, issue_valid, issue_dest_tag, issue_src1, occupancy, disp_ready);
         chk($sformatf("vec%0d_issue_valid", i), 32'(issue_valid), 32'(tbl[i].iv));
         chk($sformatf("vec%0d_issue_op", i), 32'(issue_op), 32'(tbl[i].iop));
         chk($sformatf("vec%0d_issue_dest", i), 32'(issue_dest_tag), 32'(tbl[i].idt));
         chk($sformatf("vec%0d_issue_src1", i), issue_src1, tbl[i].is1);
         chk($sformatf("vec%0d_issue_src2", i), issue_src2, tbl[i].is2);
         chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
         chk($sformatf("vec%0d_disp_ready", i), 32'(disp_ready), 32'(tbl[i].dr));
         tick();
      end

      // Full station: offered dispatch is dropped, the slot freed by issue opens next cycle
      for (int i = 0; i < DEPTH; i++) begin
         apply(mk(1, 16 + i, i, 0, 0, i, 0, 0, 100 + i, 0, 0, 0, 0, 0));
         tick();
      end
      apply(mk(1, 9, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      @(negedge clk);
      $display("full: disp_ready=%0b occ=%0d issue_dest=%0d", disp_ready, occupancy, issue_dest_tag);
      chk("full_disp_ready", 32'(disp_ready), 32'd0);
      chk("full_occupancy", 32'(occupancy), 32'd4);
      chk("full_issue_valid", 32'(issue_valid), 32'd1);
      chk("full_issue_dest", 32'(issue_dest_tag), 32'd0);
      tick();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      $display("after full issue: disp_ready=%0b occ=%0d", disp_ready, occupancy);
      chk("freed_disp_ready", 32'(disp_ready), 32'd1);
      chk("freed_occupancy", 32'(occupancy), 32'd3);
      chk("freed_issue_dest", 32'(issue_dest_tag), 32'd1);
      tick();
      for (int k = 1; k < DEPTH; k++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         @(negedge clk);
         $display("drain %0d: issue_dest=%0d occ=%0d", k, issue_dest_tag, occupancy);
         chk($sformatf("drain%0d_dest", k), 32'(issue_dest_tag), 32'(k));
         chk($sformatf("drain%0d_occ", k), 32'(occupancy), 32'(DEPTH - k));
         tick();
      end
      @(negedge clk);
      chk("drain_empty_valid", 32'(issue_valid), 32'd0);
      chk("drain_empty_occ", 32'(occupancy), 32'd0);
      tick();

      // Flush with three residents and a competing dispatch
      for (int i = 0; i < 3; i++) begin
         apply(mk(1, 32 + i, i, (i == 2) ? 0 : 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         tick();
      end
      apply(mk(1, 63, 6, 0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1));
      @(negedge clk);
      $display("flush cycle: issue_valid=%0b dest=%0d occ=%0d", issue_valid, issue_dest_tag, occupancy);
      chk("flush_cycle_occ", 32'(occupancy), 32'd3);
      chk("flush_cycle_valid", 32'(issue_valid), 32'd1);
      chk("flush_cycle_dest", 32'(issue_dest_tag), 32'd2);
      tick();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'h99, 0, 1));
      @(negedge clk);
      $display("after flush: issue_valid=%0b occ=%0d", issue_valid, occupancy);
      chk("post_flush_occ", 32'(occupancy), 32'd0);
      chk("post_flush_valid", 32'(issue_valid), 32'd0);
      chk("post_flush_ready", 32'(disp_ready), 32'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
         @(negedge clk);
         chk($sformatf("post_flush_idle%0d", k), 32'(issue_valid), 32'd0);
         tick();
      end

      // Randomized traffic against the queue model (queue position = age)
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         v = mk($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 7),
                rand_stat(), $urandom_range(0, 7), $urandom,
                rand_stat(), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                ($urandom_range(0, 63) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
         apply(v);
         @(negedge clk);
         hit_ok = v.cv && (v.ct != NO_TAG);
         pick = -1;
         for (int k = 0; k < mq.size(); k++) begin
            if (pick < 0 &&
                (mq[k].r1 || (B == 1 && hit_ok && mq[k].t1 == v.ct)) &&
                (mq[k].r2 || (B == 1 && hit_ok && mq[k].t2 == v.ct))) begin
               pick = k;
            end
         end
         chk($sformatf("rnd%0d_occ", c), 32'(occupancy), 32'(mq.size()));
         chk($sformatf("rnd%0d_disp_ready", c), 32'(disp_ready), 32'(mq.size() < DEPTH));
         chk($sformatf("rnd%0d_issue_valid", c), 32'(issue_valid), 32'(pick >= 0));
         if (pick >= 0) begin
            e_s1 = mq[pick].r1 ? mq[pick].v1 : v.cval;
            e_s2 = mq[pick].r2 ? mq[pick].v2 : v.cval;
            chk($sformatf("rnd%0d_op", c), 32'(issue_op), 32'(mq[pick].op));
            chk($sformatf("rnd%0d_dest", c), 32'(issue_dest_tag), 32'(mq[pick].dt));
            chk($sformatf("rnd%0d_src1", c), issue_src1, e_s1);
            chk($sformatf("rnd%0d_src2", c), issue_src2, e_s2);
         end
         n_before = mq.size();
         if (v.fl) begin
            mq.delete();
         end else begin
            if (pick >= 0 && v.ir) mq.delete(pick);
            if (hit_ok) begin
               for (int k = 0; k < mq.size(); k++) begin
                  if (!mq[k].r1 && mq[k].t1 == v.ct) begin
                     mq[k].r1 = 1'b1;
                     mq[k].v1 = v.cval;
                  end
                  if (!mq[k].r2 && mq[k].t2 == v.ct) begin
                     mq[k].r2 = 1'b1;
                     mq[k].v2 = v.cval;
                  end
               end
            end
            if (v.dv && n_before < DEPTH) begin
               ne.op = v.op;
               ne.dt = v.dt;
               ne.t1 = v.tg1;
               ne.t2 = v.tg2;
               ne.r1 = (v.st1 != 2'b10) || (hit_ok && v.tg1 == v.ct);
               ne.r2 = (v.st2 != 2'b10) || (hit_ok && v.tg2 == v.ct);
               ne.v1 = (v.st1 == 2'b10) ? v.cval : v.v1;
               ne.v2 = (v.st2 == 2'b10) ? v.cval : v.v2;
               mq.push_back(ne);
            end
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
